// File: rtl/hazard_pkg.sv
// Shared pipeline-control encodings for the 5-stage core.
// Pure definitions: no latency, no flow control.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard signals between decode (master) and hazard_ctrl (slave).
// Combinational bundle: zero latency, no handshake (enables act as backpressure).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             EX_MemRead;
    logic [4:0]       EX_rt;
    logic             ID_MD;
    logic             Branch;
    logic             Jump;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_Flush;
    logic             ID_EX_Flush;
    logic             MD_Go;
    logic             MD_Busy;
    logic [CNT_W-1:0] Stall_Cycles;

    modport master (
        output ID_rs, ID_rt, EX_MemRead, EX_rt, ID_MD, Branch, Jump,
        input  PC_Write, IF_ID_Write, IF_Flush, ID_EX_Flush, MD_Go, MD_Busy, Stall_Cycles
    );

    modport slave (
        input  ID_rs, ID_rt, EX_MemRead, EX_rt, ID_MD, Branch, Jump,
        output PC_Write, IF_ID_Write, IF_Flush, ID_EX_Flush, MD_Go, MD_Busy, Stall_Cycles
    );
endinterface

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Combinational, zero latency; no flow control.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    output logic       load_use
);

    // $zero is never a real dependency.
    assign load_use = EX_MemRead && (EX_rt != REG_ZERO) &&
                      ((EX_rt == ID_rs) || (EX_rt == ID_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch/jump flush and fixed-latency mult/div occupancy control.
// Outputs combinational from state+inputs (same-cycle effect); stalls by dropping PC/IF-ID enables.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [7:0]       MD_CNT_INIT = 8'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e        state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    logic pc_write, if_id_write, if_flush, id_ex_flush, md_go, md_busy;

    load_use_detect u_lud (
        .ID_rs      (hz.ID_rs),
        .ID_rt      (hz.ID_rt),
        .EX_MemRead (hz.EX_MemRead),
        .EX_rt      (hz.EX_rt),
        .load_use   (load_use)
    );

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_flush    = 1'b0;
        id_ex_flush = 1'b0;
        md_go       = 1'b0;
        md_busy     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    // Load-use masks everything else; branch/MD are re-seen next cycle.
                    if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (hz.ID_MD) begin
                        md_go    = 1'b1;
                        md_cnt_d = MD_CNT_INIT;
                        state_d  = MD_WAIT;
                    end else if (hz.Branch || hz.Jump) begin
                        if_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    md_busy     = 1'b1;
                    if (md_cnt_q == 8'd0) begin
                        state_d = RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            md_cnt_q <= 8'd0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
        end
    end

    assign hz.PC_Write     = pc_write;
    assign hz.IF_ID_Write  = if_id_write;
    assign hz.IF_Flush     = if_flush;
    assign hz.ID_EX_Flush  = id_ex_flush;
    assign hz.MD_Go        = md_go;
    assign hz.MD_Busy      = md_busy;
    assign hz.Stall_Cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized bench for hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining mult/div stall cycles and the stall count.
    int md_rem = 0;
    int cnt    = 0;

    logic last_pc, last_ifid, last_iff, last_idex, last_go, last_busy;
    int   last_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] ert,
                         input logic md, input logic br, input logic jp);
        rst           = r;
        hz.ID_rs      = rs;
        hz.ID_rt      = rt;
        hz.EX_MemRead = mr;
        hz.EX_rt      = ert;
        hz.ID_MD      = md;
        hz.Branch     = br;
        hz.Jump       = jp;
    endtask

    task automatic cycle(input string tag);
        logic e_pc, e_ifid, e_iff, e_idex, e_go, e_busy, lu;
        e_pc = 1; e_ifid = 1; e_iff = 0; e_idex = 0; e_go = 0; e_busy = 0;
        lu = hz.EX_MemRead && (hz.EX_rt != 5'd0) &&
             ((hz.EX_rt == hz.ID_rs) || (hz.EX_rt == hz.ID_rt));
        if (!rst) begin
            if (md_rem > 0) begin
                e_pc = 0; e_ifid = 0; e_idex = 1; e_busy = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_idex = 1;
            end else if (hz.ID_MD) begin
                e_go = 1;
            end else if (hz.Branch || hz.Jump) begin
                e_iff = 1;
            end
        end
        @(negedge clk);
        last_pc   = hz.PC_Write;
        last_ifid = hz.IF_ID_Write;
        last_iff  = hz.IF_Flush;
        last_idex = hz.ID_EX_Flush;
        last_go   = hz.MD_Go;
        last_busy = hz.MD_Busy;
        last_cnt  = int'(hz.Stall_Cycles);
        chk({tag, ".pc"},    32'(last_pc),   32'(e_pc));
        chk({tag, ".ifid"},  32'(last_ifid), 32'(e_ifid));
        chk({tag, ".iff"},   32'(last_iff),  32'(e_iff));
        chk({tag, ".idex"},  32'(last_idex), 32'(e_idex));
        chk({tag, ".go"},    32'(last_go),   32'(e_go));
        chk({tag, ".busy"},  32'(last_busy), 32'(e_busy));
        chk({tag, ".cnt"},   32'(last_cnt),  32'(cnt));
        @(posedge clk);
        if (rst) begin
            md_rem = 0;
            cnt    = 0;
        end else begin
            if (!e_pc) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
            if (md_rem > 0)  md_rem--;
            else if (e_go)   md_rem = MD_LAT;
        end
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle("reset");
        chk("reset_go",  32'(last_go),  32'd0);
        chk("reset_cnt", 32'(last_cnt), 32'd0);

        // Load-use on rs, then a clean cycle.
        drive(0, 8, 3, 1, 8, 0, 0, 0); cycle("lu");
        chk("lu_pc",   32'(last_pc),   32'd0);
        chk("lu_idex", 32'(last_idex), 32'd1);
        drive(0, 8, 3, 0, 8, 0, 0, 0); cycle("lu_after");
        chk("lu_after_pc",  32'(last_pc),  32'd1);
        chk("lu_after_cnt", 32'(last_cnt), 32'd1);

        // Load into $zero never stalls.
        drive(0, 0, 0, 1, 0, 0, 0, 0); cycle("lu_zero");
        chk("lu_zero_pc", 32'(last_pc), 32'd1);

        drive(0, 1, 2, 0, 0, 0, 1, 0); cycle("br");
        chk("br_iff", 32'(last_iff), 32'd1);
        chk("br_pc",  32'(last_pc),  32'd1);
        drive(0, 1, 2, 0, 0, 0, 0, 0); cycle("br_after");
        chk("br_after_iff", 32'(last_iff), 32'd0);
        chk("br_after_cnt", 32'(last_cnt), 32'd1);

        // Load-use together with branch: stall first, flush next.
        drive(0, 5, 8, 1, 8, 0, 1, 0); cycle("lubr0");
        chk("lubr0_iff", 32'(last_iff), 32'd0);
        chk("lubr0_pc",  32'(last_pc),  32'd0);
        drive(0, 5, 8, 0, 8, 0, 1, 0); cycle("lubr1");
        chk("lubr1_iff", 32'(last_iff), 32'd1);

        drive(0, 1, 2, 0, 0, 1, 0, 0); cycle("md_go");
        chk("md_go", 32'(last_go), 32'd1);
        for (int i = 0; i < MD_LAT; i++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 1); cycle("md_wait");
            chk("md_wait_busy", 32'(last_busy), 32'd1);
            chk("md_wait_iff",  32'(last_iff),  32'd0);
        end
        drive(0, 1, 2, 0, 0, 0, 0, 0); cycle("md_done");
        chk("md_done_busy", 32'(last_busy), 32'd0);
        chk("md_done_pc",   32'(last_pc),   32'd1);
        chk("md_done_cnt",  32'(last_cnt),  32'd6);

        // Reset in the second MD_WAIT cycle.
        drive(0, 1, 2, 0, 0, 1, 0, 0); cycle("mr_go");
        drive(0, 1, 2, 0, 0, 0, 0, 0); cycle("mr_w1");
        drive(1, 1, 2, 0, 0, 0, 0, 0); cycle("mr_rst");
        chk("mr_rst_busy", 32'(last_busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 2, 0, 0, 0, 0, 0); cycle("mr_post");
            chk("mr_post_busy", 32'(last_busy), 32'd0);
            chk("mr_post_go",   32'(last_go),   32'd0);
            chk("mr_post_cnt",  32'(last_cnt),  32'd0);
        end

        // Random traffic; small register range makes dependencies frequent.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0));
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
